bitrev_reorder_stream: RTL and testbench

// - Streaming bit-reversal reorder buffer for the NTT datapath: accepts one frame of N=2**LOG_N

---
 rtl/ntt_pkg.sv | 28 ++
 rtl/bitrev_pp_bank.sv | 32 +++
 rtl/bitrev_reorder_stream.sv | 87 ++++++++
 tb/tb_bitrev_reorder_stream.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT helpers: sample word type, frame length derivation and index bit reversal.
// The combinational array permutation in the NTT tree uses the same bit_reverse.
package ntt_pkg;

    localparam int SAMPLE_W = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;

    function automatic int frame_len(input int log_n);
        return 1 << log_n;
    endfunction

    // Mirrors the low log_n bits of idx; bits above log_n come out zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] idx, input int log_n);
        logic [31:0] src;
        logic [31:0] res;
        src = idx;
        res = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < log_n) begin
                res = {res[30:0], src[0]};
                src = src >> 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bitrev_pp_bank.sv
// Ping-pong sample storage: two banks of N words, one synchronous write port and one
// asynchronous read port, each selecting its own bank.
module bitrev_pp_bank
    import ntt_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int LOG_N  = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic              wr_bank,
    input  logic [LOG_N-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [LOG_N-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int N = frame_len(LOG_N);

    logic [DATA_W-1:0] mem [2][N];

    // Contents are deliberately left unreset; the full flags guard every read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/bitrev_reorder_stream.sv
// Streaming bit-reversal reorder buffer: writes each frame at bit-reversed addresses and
// reads it back sequentially, ping-ponging between two banks for 1 sample/cycle throughput.
module bitrev_reorder_stream
    import ntt_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int LOG_N  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam logic [LOG_N-1:0] LAST_IDX = {LOG_N{1'b1}};

    logic [LOG_N-1:0] wcnt;
    logic [LOG_N-1:0] rcnt;
    logic             wbank;
    logic             rbank;
    logic [1:0]       full;

    logic             in_fire;
    logic             out_fire;
    logic             wcnt_last;
    logic             rcnt_last;
    logic [LOG_N-1:0] wr_addr;

    assign in_ready  = !full[wbank];
    assign out_valid = full[rbank];
    assign out_last  = out_valid && rcnt_last;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign wcnt_last = (wcnt == LAST_IDX);
    assign rcnt_last = (rcnt == LAST_IDX);

    // Scattering on write lets the read side simply count upward.
    assign wr_addr = LOG_N'(bit_reverse(32'(wcnt), LOG_N));

    // A last write and a last read can never hit the same bank (write needs it empty,
    // read needs it full), so both flag updates are applied independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt  <= '0;
            rcnt  <= '0;
            wbank <= 1'b0;
            rbank <= 1'b0;
            full  <= 2'b00;
        end else begin
            if (in_fire) begin
                wcnt <= wcnt + 1'b1;
                if (wcnt_last) begin
                    full[wbank] <= 1'b1;
                    wbank       <= ~wbank;
                end
            end
            if (out_fire) begin
                rcnt <= rcnt + 1'b1;
                if (rcnt_last) begin
                    full[rbank] <= 1'b0;
                    rbank       <= ~rbank;
                end
            end
        end
    end

    bitrev_pp_bank #(
        .DATA_W (DATA_W),
        .LOG_N  (LOG_N)
    ) u_bank (
        .clk     (clk),
        .we      (in_fire),
        .wr_bank (wbank),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_bank (rbank),
        .rd_addr (rcnt),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_bitrev_reorder_stream.sv
// Directed bench for bitrev_reorder_stream at LOG_N=3, plus LOG_N=1 and LOG_N=4 instances
// sharing one input stream.
module tb_bitrev_reorder_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc++;

    logic       in_valid, in_ready, out_valid, out_ready, out_last;
    logic [7:0] in_data, out_data;

    logic       aux_valid, aux_out_ready;
    logic [7:0] aux_data;
    logic       a1_in_ready, a1_out_valid, a1_out_last;
    logic [7:0] a1_out_data;
    logic       a4_in_ready, a4_out_valid, a4_out_last;
    logic [7:0] a4_out_data;

    int tests_run    = 0;
    int tests_failed = 0;

    int out_q[$], last_q[$], ocyc_q[$];
    int a1_q[$], a1_last_q[$], a4_q[$], a4_last_q[$];
    int stalls = 0;
    logic count_stalls = 1'b0;

    int exp3[8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
    int exp4[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    bitrev_reorder_stream #(.DATA_W(8), .LOG_N(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    bitrev_reorder_stream #(.DATA_W(8), .LOG_N(1)) dut_n2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(aux_valid), .in_ready(a1_in_ready), .in_data(aux_data),
        .out_valid(a1_out_valid), .out_ready(aux_out_ready), .out_data(a1_out_data),
        .out_last(a1_out_last)
    );

    bitrev_reorder_stream #(.DATA_W(8), .LOG_N(4)) dut_n16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(aux_valid), .in_ready(a4_in_ready), .in_data(aux_data),
        .out_valid(a4_out_valid), .out_ready(aux_out_ready), .out_data(a4_out_data),
        .out_last(a4_out_last)
    );

    // Outputs are captured mid-cycle; a valid&ready seen here transfers on the next rising edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            out_q.push_back(int'(out_data));
            last_q.push_back(int'(out_last));
            ocyc_q.push_back(cyc);
        end
        if (a1_out_valid && aux_out_ready) begin
            a1_q.push_back(int'(a1_out_data));
            a1_last_q.push_back(int'(a1_out_last));
        end
        if (a4_out_valid && aux_out_ready) begin
            a4_q.push_back(int'(a4_out_data));
            a4_last_q.push_back(int'(a4_out_last));
        end
        if (count_stalls && in_valid && !in_ready) stalls++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        int   guard;
        logic acc;
        in_valid = 1'b1;
        in_data  = d;
        guard    = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 100);
        if (!acc) checkOutput("in_accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int g = 0;
        while (out_q.size() < n && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (out_q.size() < n) checkOutput("out_count_timeout", out_q.size(), n);
    endtask

    task automatic clear_queues();
        out_q.delete();
        last_q.delete();
        ocyc_q.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        out_ready     = 1'b0;
        aux_valid     = 1'b0;
        aux_data      = '0;
        aux_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_last", out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame, natural input order.
        out_ready = 1'b1;
        clear_queues();
        for (int i = 0; i < 7; i++) applyStimulus(8'(i));
        checkOutput("single_valid_before_last", out_valid, 0);
        applyStimulus(8'd7);
        checkOutput("single_valid_after_last", out_valid, 1);
        wait_out(8);
        for (int k = 0; k < 8; k++) begin
            if (k < out_q.size()) begin
                checkOutput($sformatf("single_data%0d", k), out_q[k], exp3[k]);
                checkOutput($sformatf("single_last%0d", k), last_q[k], (k == 7) ? 1 : 0);
            end
        end

        // Four frames back to back at full rate.
        clear_queues();
        stalls = 0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(8'(i));
            if (i == 7) count_stalls = 1'b1;
        end
        count_stalls = 1'b0;
        wait_out(32);
        checkOutput("b2b_stalls", stalls, 0);
        if (ocyc_q.size() >= 32) checkOutput("b2b_span", ocyc_q[31] - ocyc_q[0], 31);
        for (int k = 0; k < 32; k++) begin
            if (k < out_q.size()) begin
                checkOutput($sformatf("b2b_data%0d", k), out_q[k], 8 * (k / 8) + exp3[k % 8]);
                checkOutput($sformatf("b2b_last%0d", k), last_q[k], (k % 8 == 7) ? 1 : 0);
            end
        end

        // Backpressure: fill both banks, then drain.
        out_ready = 1'b0;
        clear_queues();
        for (int i = 0; i < 16; i++) applyStimulus(8'(40 + i));
        checkOutput("bp_in_ready_full", in_ready, 0);
        checkOutput("bp_out_valid", out_valid, 1);
        checkOutput("bp_out_data", out_data, 40);
        in_valid = 1'b1;
        in_data  = 8'd99;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("bp_out_data_held", out_data, 40);
        checkOutput("bp_in_ready_held", in_ready, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        begin
            logic seen_last, last_now, ready_before;
            seen_last = 1'b0;
            for (int g = 0; g < 30 && !seen_last; g++) begin
                @(negedge clk);
                last_now     = out_valid && out_last;
                ready_before = in_ready;
                @(posedge clk);
                #1;
                if (last_now) begin
                    seen_last = 1'b1;
                    checkOutput("bp_ready_before_last", ready_before, 0);
                    checkOutput("bp_ready_after_last", in_ready, 1);
                end
            end
            if (!seen_last) checkOutput("bp_last_timeout", 0, 1);
        end
        wait_out(16);
        for (int k = 0; k < 16; k++) begin
            if (k < out_q.size()) begin
                checkOutput($sformatf("bp_data%0d", k), out_q[k], 40 + 8 * (k / 8) + exp3[k % 8]);
            end
        end

        // Reset in the middle of a frame.
        clear_queues();
        for (int i = 1; i <= 3; i++) applyStimulus(8'(i));
        rst_n = 1'b0;
        #2;
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_queues();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midrst_idle_valid", out_valid, 0);
        checkOutput("midrst_idle_count", out_q.size(), 0);
        for (int i = 0; i < 8; i++) applyStimulus(8'(10 + i));
        wait_out(8);
        for (int k = 0; k < 8; k++) begin
            if (k < out_q.size()) begin
                checkOutput($sformatf("midrst_data%0d", k), out_q[k], 10 + exp3[k]);
            end
        end

        // Shared stream into the N=2 and N=16 instances.
        begin
            int aux_stalls = 0;
            int g = 0;
            aux_valid = 1'b1;
            for (int i = 0; i < 16; i++) begin
                aux_data = 8'(i);
                @(negedge clk);
                if (!a1_in_ready || !a4_in_ready) aux_stalls++;
                @(posedge clk);
                #1;
            end
            aux_valid = 1'b0;
            checkOutput("aux_stalls", aux_stalls, 0);
            while ((a1_q.size() < 16 || a4_q.size() < 16) && g < 60) begin
                @(posedge clk);
                #1;
                g++;
            end
            checkOutput("n2_count", a1_q.size(), 16);
            checkOutput("n16_count", a4_q.size(), 16);
        end
        for (int k = 0; k < 16; k++) begin
            if (k < a1_q.size()) begin
                checkOutput($sformatf("n2_data%0d", k), a1_q[k], k);
                checkOutput($sformatf("n2_last%0d", k), a1_last_q[k], k % 2);
            end
            if (k < a4_q.size()) begin
                checkOutput($sformatf("n16_data%0d", k), a4_q[k], exp4[k]);
                checkOutput($sformatf("n16_last%0d", k), a4_last_q[k], (k == 15) ? 1 : 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
